// File: rtl/audio_dsm_stereo.sv
// -----------------------------------------------------------------------------
// audio_dsm_stereo
// Stereo 1-bit audio output stage. Signed PCM pairs arrive over a valid/ready
// handshake into a single pending slot and are moved into the playing register
// once per sample period (DIV clk cycles). Each channel drives a first-order
// delta-sigma modulator whose registered carry is the pin-DAC bitstream.
//
// Parameters
//   SAMPLE_W  PCM sample width, two's complement
//   DIV       clk cycles per sample period (>= 2)
//
// Ports
//   clk       audio clock
//   reset_n   asynchronous active-low reset
//   in_valid  sample pair valid
//   in_ready  stage can accept a pair (depends on registered state only)
//   in_l      left sample, signed
//   in_r      right sample, signed
//   mute      1 = modulators play digital zero (mid-scale)
//   audio_l   left delta-sigma bitstream (registered)
//   audio_r   right delta-sigma bitstream (registered)
//   underrun  1-cycle pulse on a sample tick with no pending pair
//
// Build option
//   AUDIO_DSM_DITHER_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                        seed 16'hACE1) supplies the carry-in of both
//                        accumulator adds to break up idle tones.
// -----------------------------------------------------------------------------
module audio_dsm_stereo #(
    parameter int SAMPLE_W = 16,
    parameter int DIV      = 375
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_l,
    input  logic [SAMPLE_W-1:0] in_r,
    input  logic                mute,
    output logic                audio_l,
    output logic                audio_r,
    output logic                underrun
);

    localparam int                  CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    // Flipping the sign bit turns two's complement into offset binary.
    localparam logic [SAMPLE_W-1:0] MSB_ONE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [CNT_W-1:0]    cnt_r;
    logic                pend_valid_r;
    logic [SAMPLE_W-1:0] pend_l_r;
    logic [SAMPLE_W-1:0] pend_r_r;
    logic [SAMPLE_W-1:0] cur_l_r;
    logic [SAMPLE_W-1:0] cur_r_r;
    logic [SAMPLE_W-1:0] acc_l_r;
    logic [SAMPLE_W-1:0] acc_r_r;
    logic                audio_l_r;
    logic                audio_r_r;

    logic                tick_s;
    logic                xfer_s;
    logic                cin_s;
    logic [SAMPLE_W-1:0] u_l_s;
    logic [SAMPLE_W-1:0] u_r_s;
    logic [SAMPLE_W:0]   acc_l_next_s;
    logic [SAMPLE_W:0]   acc_r_next_s;

`ifdef AUDIO_DSM_DITHER_EN
    logic [15:0] lfsr_r;

    // Right-shifting Fibonacci form of taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Dither generator: advances every clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign cin_s = lfsr_r[0];
`else
    assign cin_s = 1'b0;
`endif

    // Pacer tick, handshake decode, modulator inputs and accumulator sums.
    always_comb begin
        tick_s = (cnt_r == CNT_MAX);
        xfer_s = in_valid & ~pend_valid_r;
        if (mute) begin
            u_l_s = MSB_ONE;
            u_r_s = MSB_ONE;
        end else begin
            u_l_s = cur_l_r ^ MSB_ONE;
            u_r_s = cur_r_r ^ MSB_ONE;
        end
        acc_l_next_s = {1'b0, acc_l_r} + {1'b0, u_l_s} + {{SAMPLE_W{1'b0}}, cin_s};
        acc_r_next_s = {1'b0, acc_r_r} + {1'b0, u_r_s} + {{SAMPLE_W{1'b0}}, cin_s};
    end

    // Sample-period counter, wraps at DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Pending slot and playing register. A transfer needs an empty slot and a
    // tick only drains a full one, so the two branches never coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid_r <= 1'b0;
            pend_l_r     <= {SAMPLE_W{1'b0}};
            pend_r_r     <= {SAMPLE_W{1'b0}};
            cur_l_r      <= {SAMPLE_W{1'b0}};
            cur_r_r      <= {SAMPLE_W{1'b0}};
        end else if (xfer_s) begin
            pend_valid_r <= 1'b1;
            pend_l_r     <= in_l;
            pend_r_r     <= in_r;
        end else if (tick_s && pend_valid_r) begin
            pend_valid_r <= 1'b0;
            cur_l_r      <= pend_l_r;
            cur_r_r      <= pend_r_r;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // Delta-sigma accumulators; the carry out of each add is the output bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_l_r   <= {SAMPLE_W{1'b0}};
            acc_r_r   <= {SAMPLE_W{1'b0}};
            audio_l_r <= 1'b0;
            audio_r_r <= 1'b0;
        end else begin
            acc_l_r   <= acc_l_next_s[SAMPLE_W-1:0];
            acc_r_r   <= acc_r_next_s[SAMPLE_W-1:0];
            audio_l_r <= acc_l_next_s[SAMPLE_W];
            audio_r_r <= acc_r_next_s[SAMPLE_W];
        end
    end

    assign in_ready = ~pend_valid_r;
    assign underrun = tick_s & ~pend_valid_r;
    assign audio_l  = audio_l_r;
    assign audio_r  = audio_r_r;

endmodule
